// File: rtl/blink_seq.sv
// rtl/blink_seq.sv - multi-channel LED pattern generator with PWM brightness
//
// Purpose: steps an NUM_LEDS-wide pattern every DIV enabled clocks in one of
// four modes (all-blink, chase, binary count, bounce) and gates the pattern
// with a global PWM brightness signal.
//
// Ports:
//   clk    - system clock, all logic on rising edge
//   rst    - synchronous active-high reset
//   en     - prescaler enable; 0 freezes the pattern
//   mode   - 0 all-blink, 1 chase, 2 binary count, 3 bounce
//   dir    - chase/count direction, 0 = left/up, 1 = right/down
//   bright - PWM duty, 0 = off, all-ones = full on
//   leds   - active-high LED drive
//   tick   - one-cycle pulse in the first cycle a new step is visible
module blink_seq #(
  parameter int NUM_LEDS = 4,
  parameter int DIV      = 25000000,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                dir,
  input  logic [PWM_BITS-1:0] bright,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_t;

  logic [CNT_W-1:0]    cnt;
  logic [NUM_LEDS-1:0] pat;
  logic [NUM_LEDS-1:0] pat_next;
  logic [NUM_LEDS-1:0] seed;
  mode_t               mode_q;
  logic                bounce_up;
  logic                bounce_up_next;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;

  // Pattern loaded when the mode input differs from the registered mode.
  always_comb begin
    seed = '0;
    case (mode)
      2'd1:    seed = dir ? {1'b1, {(NUM_LEDS-1){1'b0}}} : NUM_LEDS'(1);
      2'd3:    seed = NUM_LEDS'(1);
      default: seed = '0;
    endcase
  end

  // Pattern after one step in the registered mode.
  always_comb begin
    pat_next       = pat;
    bounce_up_next = bounce_up;
    case (mode_q)
      MODE_BLINK: pat_next = ~pat;
      MODE_CHASE: pat_next = dir ? {pat[0], pat[NUM_LEDS-1:1]}
                                 : {pat[NUM_LEDS-2:0], pat[NUM_LEDS-1]};
      MODE_COUNT: pat_next = dir ? pat - NUM_LEDS'(1) : pat + NUM_LEDS'(1);
      MODE_BOUNCE: begin
        // Turn around at an end bit in the same step, so neither end repeats.
        if (bounce_up) begin
          if (pat[NUM_LEDS-1]) begin
            bounce_up_next = 1'b0;
            pat_next       = pat >> 1;
          end else begin
            pat_next = pat << 1;
          end
        end else begin
          if (pat[0]) begin
            bounce_up_next = 1'b1;
            pat_next       = pat << 1;
          end else begin
            pat_next = pat >> 1;
          end
        end
      end
      default: pat_next = pat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      pat       <= '0;
      mode_q    <= MODE_BLINK;
      bounce_up <= 1'b1;
      pwm_cnt   <= '0;
      pwm_on    <= 1'b0;
      tick      <= 1'b0;
    end else begin
      mode_q  <= mode_t'(mode);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      pwm_on  <= (&bright) | (pwm_cnt < bright);
      tick    <= 1'b0;
      // A mode change wins over a step edge and reseeds even when en=0.
      if (mode != mode_q) begin
        pat       <= seed;
        cnt       <= '0;
        bounce_up <= 1'b1;
      end else if (en) begin
        if (cnt == CNT_LAST) begin
          cnt       <= '0;
          pat       <= pat_next;
          bounce_up <= bounce_up_next;
          tick      <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign leds = pat & {NUM_LEDS{pwm_on}};

endmodule

// File: tb/tb_blink_seq.sv
// tb/tb_blink_seq.sv - table-driven bench for blink_seq (NUM_LEDS=4, DIV=4)
module tb_blink_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       dir;
  logic [3:0] bright;
  logic [3:0] leds;
  logic       tick;

  int total = 0;
  int bad   = 0;

  blink_seq #(.NUM_LEDS(4), .DIV(4), .PWM_BITS(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .bright(bright), .leds(leds), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       dir;
    int         reps;
    logic [3:0] leds;
    logic       tick;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] m, input logic d, input int r,
                     input logic [3:0] l, input logic t);
    vec_t v;
    v.mode = m; v.dir = d; v.reps = r; v.leds = l; v.tick = t;
    vecs.push_back(v);
  endtask

  // Three quiet cycles showing prev, then the step cycle showing next.
  task automatic step(input logic [1:0] m, input logic d,
                      input logic [3:0] prev, input logic [3:0] next);
    add(m, d, 3, prev, 1'b0);
    add(m, d, 1, next, 1'b1);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_tick(input int max, output int gap);
    gap = -1;
    for (int i = 1; i <= max; i++) begin
      cyc();
      if (tick) begin
        gap = i;
        break;
      end
    end
  endtask

  int gap;
  int on_cnt;
  int off_cnt;

  initial begin
    // Test 1: mode 0 blink
    step(0, 0, 4'h0, 4'hF); step(0, 0, 4'hF, 4'h0); step(0, 0, 4'h0, 4'hF);
    // Test 2: chase left, then right without reseed
    add(1, 0, 1, 4'h1, 1'b0);
    step(1, 0, 4'h1, 4'h2); step(1, 0, 4'h2, 4'h4); step(1, 0, 4'h4, 4'h8);
    step(1, 0, 4'h8, 4'h1); step(1, 0, 4'h1, 4'h2); step(1, 0, 4'h2, 4'h4);
    step(1, 1, 4'h4, 4'h2); step(1, 1, 4'h2, 4'h1); step(1, 1, 4'h1, 4'h8);
    // Mode change lands on a would-be step edge: reseed, no tick
    add(1, 1, 3, 4'h8, 1'b0);
    add(2, 1, 1, 4'h0, 1'b0);
    // Test 3: count down, then up
    step(2, 1, 4'h0, 4'hF); step(2, 1, 4'hF, 4'hE); step(2, 1, 4'hE, 4'hD);
    step(2, 0, 4'hD, 4'hE);
    // Test 4: bounce, dir toggling must not matter
    add(3, 1, 1, 4'h1, 1'b0);
    step(3, 0, 4'h1, 4'h2); step(3, 1, 4'h2, 4'h4); step(3, 0, 4'h4, 4'h8);
    step(3, 1, 4'h8, 4'h4); step(3, 0, 4'h4, 4'h2); step(3, 1, 4'h2, 4'h1);
    step(3, 0, 4'h1, 4'h2);

    // Reset state
    rst = 1'b1; en = 1'b0; mode = 2'd0; dir = 1'b0; bright = 4'hF;
    @(negedge clk);
    cyc();
    chk("reset_leds", int'(leds), 0);
    chk("reset_tick", int'(tick), 0);
    rst = 1'b0; en = 1'b1;

    foreach (vecs[k]) begin
      for (int r = 0; r < vecs[k].reps; r++) begin
        mode = vecs[k].mode;
        dir  = vecs[k].dir;
        cyc();
        chk($sformatf("vec%0d_leds", k), int'(leds), int'(vecs[k].leds));
        chk($sformatf("vec%0d_tick", k), int'(tick), int'(vecs[k].tick));
      end
    end

    // Test 5: en=0 stall delays the tick by the stall length
    mode = 2'd0; dir = 1'b0; en = 1'b1;
    cyc();
    chk("stall_reseed_leds", int'(leds), 0);
    chk("stall_reseed_tick", int'(tick), 0);
    cyc(); cyc();
    chk("stall_pre_tick", int'(tick), 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold_leds", int'(leds), 0);
      chk("stall_hold_tick", int'(tick), 0);
    end
    en = 1'b1;
    wait_tick(10, gap);
    chk("stall_resume_gap", gap, 2);
    chk("stall_resume_leds", int'(leds), 15);
    // Mode change while disabled still reseeds; step needs DIV enabled edges
    en = 1'b0; mode = 2'd1;
    cyc();
    chk("en0_reseed_leds", int'(leds), 1);
    chk("en0_reseed_tick", int'(tick), 0);
    cyc(); cyc();
    chk("en0_hold_leds", int'(leds), 1);
    en = 1'b1;
    wait_tick(10, gap);
    chk("en0_resume_gap", gap, 4);
    chk("en0_resume_leds", int'(leds), 2);

    // Test 6: PWM duty with a frozen 1111 pattern
    mode = 2'd2; dir = 1'b1;
    cyc();
    wait_tick(10, gap);
    chk("pwm_setup_gap", gap, 4);
    chk("pwm_setup_leds", int'(leds), 15);
    en = 1'b0; bright = 4'd4;
    cyc();
    on_cnt = 0; off_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      if (leds == 4'hF) on_cnt++;
      else if (leds == 4'h0) off_cnt++;
    end
    chk("pwm4_on", on_cnt, 8);
    chk("pwm4_off", off_cnt, 24);
    bright = 4'd0;
    cyc();
    off_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      if (leds == 4'h0) off_cnt++;
    end
    chk("pwm0_off", off_cnt, 32);

    // Reset mid-pattern, on an edge that would otherwise step
    bright = 4'hF; en = 1'b1;
    cyc(); cyc(); cyc();
    chk("prerst_tick", int'(tick), 0);
    rst = 1'b1;
    cyc();
    chk("midrst_leds", int'(leds), 0);
    chk("midrst_tick", int'(tick), 0);
    rst = 1'b0; mode = 2'd0;
    wait_tick(10, gap);
    chk("postrst_gap", gap, 4);
    chk("postrst_leds", int'(leds), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blink_seq.md
Name: blink_seq

Overview:
Parametrised multi-channel LED pattern generator; next generation of the fixed four-LED blinker. It drives NUM_LEDS outputs from a prescaled tick in one of four run-time selectable patterns: all-blink, chase, binary count and bounce. Brightness is set by a global PWM duty control. It sits directly at board top level, between the system clock/reset and the LED pins.

Parameters:
NUM_LEDS, 4, number of LED outputs (>=2)
DIV, 25000000, clk cycles per pattern step (>=1)
PWM_BITS, 4, width of brightness PWM counter and bright input (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  1 = prescaler runs; 0 = pattern frozen
mode  input  2  0 all-blink, 1 chase, 2 binary count, 3 bounce
dir  input  1  chase/count direction: 0 = left/up, 1 = right/down; ignored in modes 0 and 3
bright  input  PWM_BITS  brightness duty; 0 = off, all-ones = full on
leds  output  NUM_LEDS  LED drive, active-high
tick  output  1  one-cycle pulse in the first cycle a new pattern step is visible

Behaviour:
- Reset (sync, rst=1 at edge): prescaler cnt=0, pattern pat=0, mode_q=0, bounce direction=up, pwm_cnt=0, pwm_on=0, tick=0. Consequently leds=0 and tick=0 in the cycle after the reset edge. Reset mid-operation behaves identically.
- Prescaler: cnt counts 0..DIV-1 on edges where en=1 and wraps to 0. A step edge is an edge with en=1 and cnt==DIV-1. With DIV=1, every edge with en=1 is a step edge.
- en=0: cnt, pat and bounce direction hold; tick=0. Counting resumes from the held cnt.
- tick: registered. It is 1 for exactly the cycle after a step edge, otherwise 0.
- Mode change: mode_q registers mode. On any edge where mode!=mode_q, regardless of en:
  - pat loads the seed for the new mode;
  - cnt is cleared;
  - bounce direction is set to up;
  - no step occurs and tick=0.
  Seeds: mode0 = all zeros; mode1 = bit0 if dir=0, else bit NUM_LEDS-1; mode2 = all zeros; mode3 = bit0.
- Step update, by mode_q:
  - mode0: pat <= ~pat.
  - mode1: dir=0 rotates left (bit i to i+1, MSB wraps to bit0); dir=1 rotates right.
  - mode2: dir=0 gives pat+1, dir=1 gives pat-1, both modulo 2^NUM_LEDS.
  - mode3: a one-hot bit moves toward the MSB while direction is up. On reaching the MSB, direction flips and the next step moves toward bit0; it flips again at bit0. No end bit repeats.
- A dir change within a mode takes effect at the next step without reseeding.
- PWM: pwm_cnt is a free-running PWM_BITS counter that increments every clk and is not gated by en. pwm_on is registered: pwm_on <= (bright == all-ones) | (pwm_cnt < bright).
- leds = pat AND replicate(pwm_on). This is combinational from registers only.
- Simultaneous events: rst beats everything. A mode change beats a step edge in the same cycle.

Test Plan:
1. NUM_LEDS=4, DIV=4, bright=4'hF, mode=0, en=1 after reset -> tick pulses every 4 cycles; leds 0000 -> 1111 -> 0000 -> 1111.
2. mode=1, dir=0 -> reseed to 0001 with no tick, then steps 0010, 0100, 1000, 0001. Setting dir=1 while leds=0100 -> next step 0010, no reseed.
3. mode=2, dir=1 -> 0000, 1111, 1110, 1101. Switching dir=0 -> next step 1110.
4. mode=3 -> 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. Drive dir toggling throughout -> sequence unchanged.
5. mode=0, en=0 for 3 cycles mid-count -> tick delayed by exactly 3 cycles and pattern held. Change mode while en=0 -> pat reseeds, next tick comes DIV cycles after en returns to 1.
6. bright=4, PWM_BITS=4, steady pattern 1111 -> leds=1111 for 4 of every 16 cycles. bright=0 -> leds stay 0000. Assert rst mid-pattern -> leds=0000 and tick=0 in the cycle after the reset edge.
